// File: rtl/cpu_rmc_core.sv
// cpu_rmc_core: single-cycle 32-bit CPU acting as a read-memory controller between two FIFOs.
module cpu_rmc_mem #(
  parameter int DEPTH = 256,
  parameter int W = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

module cpu_rmc_core #(
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  halt,
  input  logic [DATA_WIDTH-1:0] req_fifo_data,
  output logic                  req_fifo_deq,
  input  logic                  req_fifo_rdempty,
  output logic [DATA_WIDTH-1:0] read_fifo_data_in,
  output logic                  read_fifo_enq,
  input  logic                  read_fifo_wrfull
);
  localparam int PW = $clog2(IMEM_DEPTH);
  localparam int AW = $clog2(DMEM_DEPTH);
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE,
    OP_JMP, OP_POP, OP_PUSH, OP_HALT, OP_MUL
  } op_e;
  logic [PW-1:0]         pc_q, pc_d, pc_inc, pc_br;
  logic                  halt_q, halt_d;
  logic [DATA_WIDTH-1:0] rf_q [16];
  logic [DATA_WIDTH-1:0] rf_d [16];
  logic [DATA_WIDTH-1:0] instr, rs_v, rt_v, sext, wb, dm_rdata;
  logic [AW-1:0]         dm_addr;
  logic                  dm_we, wb_en;
  op_e                   op;
  cpu_rmc_mem #(.DEPTH(IMEM_DEPTH), .W(DATA_WIDTH)) inst_mem (
    .clk(clk), .we(1'b0), .addr(pc_q), .wdata('0), .rdata(instr)
  );
  cpu_rmc_mem #(.DEPTH(DMEM_DEPTH), .W(DATA_WIDTH)) data_mem (
    .clk(clk), .we(dm_we), .addr(dm_addr), .wdata(rt_v), .rdata(dm_rdata)
  );
  assign op = op_e'(instr[31:28]);
  assign rs_v = rf_q[instr[23:20]];
  assign rt_v = rf_q[instr[19:16]];
  assign sext = {{(DATA_WIDTH-16){instr[15]}}, instr[15:0]};
  assign dm_addr = rs_v[AW-1:0] + instr[AW-1:0];
  assign pc_inc = pc_q + PW'(1);
  assign pc_br = pc_inc + instr[PW-1:0];
  assign halt = halt_q;
  always_comb begin
    pc_d = pc_q;
    halt_d = halt_q;
    rf_d = rf_q;
    dm_we = 1'b0;
    wb_en = 1'b0;
    wb = '0;
    req_fifo_deq = 1'b0;
    read_fifo_enq = 1'b0;
    read_fifo_data_in = (op == OP_PUSH) ? rs_v : '0;
    if (rstn && !halt_q) begin
      pc_d = pc_inc;
      case (op)
        OP_ADD:  begin wb_en = 1'b1; wb = rs_v + rt_v; end
        OP_SUB:  begin wb_en = 1'b1; wb = rs_v - rt_v; end
        OP_ADDI: begin wb_en = 1'b1; wb = rs_v + sext; end
        OP_LW:   begin wb_en = 1'b1; wb = dm_rdata; end
        OP_SW:   dm_we = 1'b1;
        OP_BEQ:  pc_d = (rs_v == rt_v) ? pc_br : pc_inc;
        OP_BNE:  pc_d = (rs_v != rt_v) ? pc_br : pc_inc;
        OP_JMP:  pc_d = instr[PW-1:0];
        OP_POP: begin
          req_fifo_deq = !req_fifo_rdempty;
          wb_en = !req_fifo_rdempty;
          wb = req_fifo_data;
          pc_d = req_fifo_rdempty ? pc_q : pc_inc;
        end
        OP_PUSH: begin
          read_fifo_enq = !read_fifo_wrfull;
          pc_d = read_fifo_wrfull ? pc_q : pc_inc;
        end
        OP_HALT: begin halt_d = 1'b1; pc_d = pc_q; end
`ifdef CPU_RMC_MUL_EN
        OP_MUL:  begin wb_en = 1'b1; wb = rs_v * rt_v; end
`endif
        default: ;
      endcase
      if (wb_en && instr[27:24] != 4'd0) rf_d[instr[27:24]] = wb;
    end
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      pc_q <= '0;
      halt_q <= 1'b0;
      rf_q <= '{default: '0};
    end else begin
      pc_q <= pc_d;
      halt_q <= halt_d;
      rf_q <= rf_d;
    end
endmodule

// File: tb/tb_cpu_rmc_core.sv
// tb_cpu_rmc_core: directed bench for cpu_rmc_core with queue-modelled request and read FIFOs.
module tb_cpu_rmc_core;
  localparam logic [31:0] HALT_I = 32'hB000_0000;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        halt;
  logic [31:0] req_fifo_data = '0;
  logic        req_fifo_deq;
  logic        req_fifo_rdempty = 1'b1;
  logic [31:0] read_fifo_data_in;
  logic        read_fifo_enq;
  logic        read_fifo_wrfull = 1'b0;
  logic [31:0] req_q [$];
  logic [31:0] rd_q [$];
  logic [31:0] out_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] prog [$];
  logic        cons_en = 1'b0;
  logic        sd, se, sc;
  logic [31:0] sv;
  int          n_chk = 0;
  int          n_err = 0;

  cpu_rmc_core dut (
    .clk(clk), .rstn(rstn), .halt(halt),
    .req_fifo_data(req_fifo_data), .req_fifo_deq(req_fifo_deq), .req_fifo_rdempty(req_fifo_rdempty),
    .read_fifo_data_in(read_fifo_data_in), .read_fifo_enq(read_fifo_enq), .read_fifo_wrfull(read_fifo_wrfull)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [3:0] op, rd, rs, rt, input logic [15:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  function automatic logic [31:0] dval(input int a);
    return 32'hD000_0000 + a * 257;
  endfunction

  task automatic upd();
    req_fifo_rdempty = (req_q.size() == 0);
    req_fifo_data = (req_q.size() == 0) ? 32'h0 : req_q[0];
    read_fifo_wrfull = (rd_q.size() >= 4);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // FIFO models: handshakes are sampled mid-cycle and applied just after the edge.
  always begin
    @(negedge clk);
    sd = req_fifo_deq;
    se = read_fifo_enq;
    sv = read_fifo_data_in;
    sc = cons_en && rd_q.size() > 0;
    if (sd) chk("deq_while_empty", {31'h0, req_fifo_rdempty}, 32'h0);
    if (se) chk("enq_while_full", {31'h0, read_fifo_wrfull}, 32'h0);
    @(posedge clk);
    #1;
    if (sd && req_q.size() > 0) void'(req_q.pop_front());
    if (sc) out_q.push_back(rd_q.pop_front());
    if (se) rd_q.push_back(sv);
    upd();
  end

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < 256; i++) dut.inst_mem.mem[i] = (i < prog.size()) ? prog[i] : HALT_I;
    rd_q.delete();
    out_q.delete();
    upd();
    step();
    step();
    chk("rst_halt", {31'h0, halt}, 32'h0);
    chk("rst_pc", {24'h0, dut.pc_q}, 32'h0);
    chk("rst_deq", {31'h0, req_fifo_deq}, 32'h0);
    chk("rst_enq", {31'h0, read_fifo_enq}, 32'h0);
    rstn = 1'b1;
  endtask

  task automatic run_to_halt(input int n);
    int i;
    i = 0;
    while (!halt && i < n) begin
      step();
      i++;
    end
    chk("halt_reached", {31'h0, halt}, 32'h1);
  endtask

  typedef struct { int addr; int cnt; } req_t;
  req_t reqs [5];
  int p0;

  initial begin
    // ALU
    prog = {ins(3, 1, 0, 0, 16'd5), ins(3, 2, 0, 0, 16'hFFFD), ins(1, 3, 1, 2, 0), ins(2, 4, 2, 1, 0), HALT_I};
    do_reset();
    run_to_halt(50);
    chk("alu_r1", dut.rf_q[1], 32'd5);
    chk("alu_r2", dut.rf_q[2], 32'hFFFF_FFFD);
    chk("alu_add", dut.rf_q[3], 32'd2);
    chk("alu_sub", dut.rf_q[4], 32'hFFFF_FFF8);
    repeat (5) step();
    chk("halt_sticky", {31'h0, halt}, 32'h1);
    chk("halt_pc", {24'h0, dut.pc_q}, 32'd4);

    // memory, branches, jump, r0 and address wrap
    prog = {ins(3, 0, 0, 0, 16'd7), ins(3, 1, 0, 0, 16'h1234), ins(5, 0, 0, 1, 16'd4), ins(4, 5, 0, 0, 16'd4),
            ins(6, 0, 5, 5, 16'd1), ins(3, 6, 0, 0, 16'h77), ins(7, 0, 5, 5, 16'd1), ins(3, 7, 0, 0, 16'd9),
            ins(8, 0, 0, 0, 16'd10), ins(3, 7, 0, 0, 16'h55), ins(4, 9, 0, 0, 16'h0104), HALT_I};
    do_reset();
    run_to_halt(50);
    chk("r0_zero", dut.rf_q[0], 32'h0);
    chk("sw_mem", dut.data_mem.mem[4], 32'h1234);
    chk("lw_r5", dut.rf_q[5], 32'h1234);
    chk("beq_skip", dut.rf_q[6], 32'h0);
    chk("bne_jmp_r7", dut.rf_q[7], 32'd9);
    chk("lw_wrap", dut.rf_q[9], 32'h1234);
    chk("mem_pc", {24'h0, dut.pc_q}, 32'd11);

    // POP stall on empty, PUSH stall on full
    req_q.delete();
    prog = {ins(9, 1, 0, 0, 0), ins(10, 0, 1, 0, 0), HALT_I};
    do_reset();
    for (int i = 0; i < 4; i++) rd_q.push_back(32'hAA00 + i);
    upd();
    repeat (5) step();
    chk("pop_stall_pc", {24'h0, dut.pc_q}, 32'h0);
    chk("pop_stall_deq", {31'h0, req_fifo_deq}, 32'h0);
    chk("pop_data_zero", read_fifo_data_in, 32'h0);
    req_q.push_back(32'h10);
    upd();
    #1;
    chk("pop_deq", {31'h0, req_fifo_deq}, 32'h1);
    step();
    chk("pop_rd", dut.rf_q[1], 32'h10);
    chk("pop_once", req_q.size(), 0);
    chk("pop_deq_drop", {31'h0, req_fifo_deq}, 32'h0);
    repeat (3) step();
    chk("push_stall_pc", {24'h0, dut.pc_q}, 32'd1);
    chk("push_stall_enq", {31'h0, read_fifo_enq}, 32'h0);
    chk("push_data", read_fifo_data_in, 32'h10);
    cons_en = 1'b1;
    run_to_halt(30);
    repeat (6) step();
    cons_en = 1'b0;
    chk("push_cnt", out_q.size(), 5);
    if (out_q.size() == 5) chk("push_word", out_q[4], 32'h10);

    // request-driven bulk reads through a depth-4 read FIFO
    reqs = '{'{10, 3}, '{200, 8}, '{250, 8}, '{77, 0}, '{5, 4}};
    req_q.delete();
    exp_q.delete();
    foreach (reqs[k]) begin
      req_q.push_back(reqs[k].addr);
      req_q.push_back(reqs[k].cnt);
      for (int j = 0; j < reqs[k].cnt; j++) exp_q.push_back(dval((reqs[k].addr + j) % 256));
    end
    for (int i = 0; i < 256; i++) dut.data_mem.mem[i] = dval(i);
    prog = {ins(9, 1, 0, 0, 0), ins(9, 2, 0, 0, 0), ins(6, 0, 2, 0, 16'hFFFD), ins(4, 3, 1, 0, 0),
            ins(10, 0, 3, 0, 0), ins(3, 1, 1, 0, 16'd1), ins(3, 2, 2, 0, 16'hFFFF), ins(7, 0, 2, 0, 16'hFFFB),
            ins(8, 0, 0, 0, 0)};
    do_reset();
    p0 = 0;
    while (rd_q.size() < 4 && p0 < 300) begin
      step();
      p0++;
    end
    chk("rdfifo_filled", rd_q.size(), 4);
    repeat (5) step();
    chk("full_stall_pc", {24'h0, dut.pc_q}, 32'd4);
    chk("full_stall_enq", {31'h0, read_fifo_enq}, 32'h0);
    chk("full_no_extra", rd_q.size(), 4);
    cons_en = 1'b1;
    #100;
    cons_en = 1'b0;
    repeat (3) step();
    cons_en = 1'b1;
    p0 = 0;
    while (out_q.size() < exp_q.size() && p0 < 1000) begin
      step();
      p0++;
    end
    cons_en = 1'b0;
    chk("bulk_cnt", out_q.size(), exp_q.size());
    foreach (exp_q[k]) if (k < out_q.size()) chk($sformatf("bulk_w%0d", k), out_q[k], exp_q[k]);
    repeat (3) step();
    chk("bulk_req_drained", req_q.size(), 0);
    chk("bulk_idle_pc", {24'h0, dut.pc_q}, 32'h0);

    // HALT blocks FIFO traffic; MUL or NOP on opcode C; D acts as NOP
    req_q.delete();
    req_q.push_back(32'h99);
    prog = {ins(3, 1, 0, 0, 16'd7), ins(3, 2, 0, 0, 16'd6), ins(12, 3, 1, 2, 0), ins(13, 5, 1, 2, 16'd1),
            HALT_I, ins(9, 4, 0, 0, 0)};
    do_reset();
    run_to_halt(30);
    repeat (5) step();
`ifdef CPU_RMC_MUL_EN
    chk("mul", dut.rf_q[3], 32'd42);
`else
    chk("mul_nop", dut.rf_q[3], 32'd0);
`endif
    chk("opd_nop", dut.rf_q[5], 32'h0);
    chk("halt_no_pop", dut.rf_q[4], 32'h0);
    chk("halt_req_kept", req_q.size(), 1);
    chk("halt_deq", {31'h0, req_fifo_deq}, 32'h0);
    chk("halt_pc2", {24'h0, dut.pc_q}, 32'd4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
